xcorr_engine: RTL

XCORR_ENGINE -- requirements
Module: xcorr_engine

---
 rtl/xcorr_pkg.sv | 26 ++
 rtl/xcorr_lane.sv | 118 +++++++++++
 rtl/xcorr_engine.sv | 130 +++++++++++++
 3 files changed

// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared types and width helpers for the cross-correlation engine.
// Holds the FSM state enum, clog2, and the accumulator width derivation.
package xcorr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Full-precision product plus growth for WINDOW terms.
  function automatic int acc_width(input int dw, input int win);
    return 2 * dw + clog2(win);
  endfunction

endpackage

// File: rtl/xcorr_lane.sv
// xcorr_lane: one other-channel lane: sample, multiply, accumulate, best-lag track.
// Ports: clk/reset, clr_i (run start), vld_i/last_i/fin_i/lag_i tags aligned with
// ref_i/oth_i data, best_off_o/best_sum_o final winning lag and sum.
module xcorr_lane
  import xcorr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int WINDOW = 180,
  parameter int ADDR_W = 8,
  parameter int ACC_W  = acc_width(DATA_W, WINDOW)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     vld_i,
  input  logic                     last_i,
  input  logic                     fin_i,
  input  logic [ADDR_W-1:0]        lag_i,
  input  logic signed [DATA_W-1:0] ref_i,
  input  logic signed [DATA_W-1:0] oth_i,
  output logic [ADDR_W-1:0]        best_off_o,
  output logic signed [ACC_W-1:0]  best_sum_o
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [DATA_W-1:0] a_q, b_q;
  logic                     v2_q, l2_q, f2_q;
  logic [ADDR_W-1:0]        g2_q;
  logic signed [PW-1:0]     prod_q;
  logic                     v3_q, l3_q, f3_q;
  logic [ADDR_W-1:0]        g3_q;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  wbest_q, wbest_d;
  logic [ADDR_W-1:0]        woff_q, woff_d;
  logic signed [ACC_W-1:0]  bsum_q, bsum_d;
  logic [ADDR_W-1:0]        boff_q, boff_d;

  logic signed [ACC_W-1:0]  sum;
  logic                     gt;

  assign sum = acc_q + ACC_W'(prod_q);
  assign gt  = sum > wbest_q;

  // Working best is private; the visible best only moves at the
  // final lag so outputs hold their old values through a run.
  always_comb begin
    acc_d   = acc_q;
    wbest_d = wbest_q;
    woff_d  = woff_q;
    bsum_d  = bsum_q;
    boff_d  = boff_q;
    if (clr_i) begin
      acc_d   = '0;
      wbest_d = ACC_MIN;
      woff_d  = '0;
    end else if (v3_q) begin
      if (l3_q) begin
        acc_d = '0;
        if (gt) begin
          wbest_d = sum;
          woff_d  = g3_q;
        end
        if (f3_q) begin
          bsum_d = gt ? sum : wbest_q;
          boff_d = gt ? g3_q : woff_q;
        end
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      v2_q    <= 1'b0;
      l2_q    <= 1'b0;
      f2_q    <= 1'b0;
      g2_q    <= '0;
      prod_q  <= '0;
      v3_q    <= 1'b0;
      l3_q    <= 1'b0;
      f3_q    <= 1'b0;
      g3_q    <= '0;
      acc_q   <= '0;
      wbest_q <= '0;
      woff_q  <= '0;
      bsum_q  <= '0;
      boff_q  <= '0;
    end else begin
      a_q     <= ref_i;
      b_q     <= oth_i;
      v2_q    <= vld_i;
      l2_q    <= last_i;
      f2_q    <= fin_i;
      g2_q    <= lag_i;
      prod_q  <= PW'(a_q) * PW'(b_q);
      v3_q    <= v2_q;
      l3_q    <= l2_q;
      f3_q    <= f2_q;
      g3_q    <= g2_q;
      acc_q   <= acc_d;
      wbest_q <= wbest_d;
      woff_q  <= woff_d;
      bsum_q  <= bsum_d;
      boff_q  <= boff_d;
    end
  end

  assign best_off_o = boff_q;
  assign best_sum_o = bsum_q;

endmodule

// File: rtl/xcorr_engine.sv
// xcorr_engine: lag-search cross-correlation of NUM_OTHERS channels vs a reference.
// Ports: clk/reset, start/busy/done handshake, ref_addr/oth_addr buffer reads,
// ref_data/oth_data samples (1-cycle latency), best_offset/best_sum per lane.
module xcorr_engine
  import xcorr_pkg::*;
#(
  parameter int NUM_OTHERS = 2,
  parameter int DATA_W     = 16,
  parameter int WINDOW     = 180,
  parameter int MAX_DEV    = 30,
  parameter int ADDR_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         ref_addr,
  output logic [ADDR_W-1:0]         oth_addr,
  input  logic signed [DATA_W-1:0]  ref_data,
  input  logic [NUM_OTHERS*DATA_W-1:0] oth_data,
  output logic [NUM_OTHERS*ADDR_W-1:0] best_offset,
  output logic signed [NUM_OTHERS*acc_width(DATA_W, WINDOW)-1:0] best_sum
);

  localparam int ACC_W = acc_width(DATA_W, WINDOW);
  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(WINDOW - 1);
  localparam logic [ADDR_W-1:0] D_LAST = ADDR_W'(2 * MAX_DEV);
  localparam logic [ADDR_W-1:0] OFS    = ADDR_W'(MAX_DEV);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] w_q, w_d;
  logic [ADDR_W-1:0] d_q, d_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic              accept;

  logic              iss, ilast, ifin;
  logic              v1_q, l1_q, f1_q;
  logic [ADDR_W-1:0] g1_q;

  assign iss   = state_q == RUN;
  assign ilast = iss && (w_q == W_LAST);
  assign ifin  = ilast && (d_q == D_LAST);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    d_d     = d_q;
    dcnt_d  = dcnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          w_d     = '0;
          d_d     = '0;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (w_q == W_LAST) begin
          w_d = '0;
          if (d_q == D_LAST) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end else begin
            d_d = d_q + 1'b1;
          end
        end else begin
          w_d = w_q + 1'b1;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == 2'd2) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      w_q     <= '0;
      d_q     <= '0;
      dcnt_q  <= '0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      f1_q    <= 1'b0;
      g1_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      d_q     <= d_d;
      dcnt_q  <= dcnt_d;
      v1_q    <= iss;
      l1_q    <= ilast;
      f1_q    <= ifin;
      g1_q    <= d_q;
    end
  end

  // Gating with reset drops the handshake in the reset cycle itself.
  assign busy = ~reset & ((state_q == RUN) | (state_q == DRAIN));
  assign done = ~reset & (state_q == FINISH);
  assign ref_addr = (iss && !reset) ? w_q + OFS : '0;
  assign oth_addr = (iss && !reset) ? w_q + d_q : '0;

  for (genvar k = 0; k < NUM_OTHERS; k++) begin : g_lane
    xcorr_lane #(
      .DATA_W(DATA_W),
      .WINDOW(WINDOW),
      .ADDR_W(ADDR_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (accept),
      .vld_i     (v1_q),
      .last_i    (l1_q),
      .fin_i     (f1_q),
      .lag_i     (g1_q),
      .ref_i     (ref_data),
      .oth_i     (oth_data[k*DATA_W +: DATA_W]),
      .best_off_o(best_offset[k*ADDR_W +: ADDR_W]),
      .best_sum_o(best_sum[k*ACC_W +: ACC_W])
    );
  end

endmodule
